mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/HI/LO width; SHALL support any even value >= 4.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: op_valid  input  1  request present.
REQ-005 Port: op_ready  output  1  unit idle, can accept; SHALL be high exactly when the FSM is in IDLE.
REQ-006 Port: op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-007 Port: A  input  DATA_WIDTH  multiplicand/dividend/move source.
REQ-008 Port: B  input  DATA_WIDTH  multiplier/divisor.
REQ-009 Port: hi  output  DATA_WIDTH  HI register (product upper half / remainder).
REQ-010 Port: lo  output  DATA_WIDTH  LO register (product lower half / quotient).
REQ-011 Port: done  output  1  one-cycle pulse: multiply/divide completed.
REQ-012 Port: div_zero  output  1  one-cycle pulse with done: divide by zero.

Function
REQ-013 Accept SHALL occur on a rising edge with op_valid=1 and op_ready=1; op, A and B SHALL be captured internally at accept; later input changes SHALL not affect the operation.
REQ-014 op_valid while op_ready=0 SHALL be ignored; no queueing.
REQ-015 Reserved op codes SHALL be accepted and discarded: no state change, no done.
REQ-016 MTHI/MTLO SHALL write A to hi/lo on the accept edge, stay in IDLE, assert no done.
REQ-017 FSM states: IDLE, RUN, FIX; IDLE->RUN on MULT/MULTU/DIV/DIVU accept; RUN->FIX after exactly DATA_WIDTH iteration edges; FIX->IDLE on the next edge.
REQ-018 Latency: accept edge E0; iterations on E1..EN (N=DATA_WIDTH); on E(N+1) hi/lo SHALL update, done SHALL pulse for one cycle and op_ready SHALL return high; earliest next accept E(N+2).
REQ-019 Multiply: one shift-add step per RUN cycle on operand magnitudes; signed ops SHALL negate the 2N-bit product in FIX when operand signs differ; {hi,lo} = exact 2N-bit product.
REQ-020 Divide: one restoring shift-subtract step per RUN cycle on magnitudes; unsigned for DIVU.
REQ-021 DIV: quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign; fix-up in FIX.
REQ-022 DIV of most-negative by -1: lo = most-negative value (wrap), hi = 0.
REQ-023 B=0 on DIV/DIVU: SHALL skip RUN; on E1 done=1 and div_zero=1, hi/lo unchanged, return to IDLE.
REQ-024 hi/lo SHALL only change on MTHI/MTLO accept or multiply/divide completion.
REQ-025 done and div_zero SHALL be registered outputs, never high outside the completion cycle.

Reset
REQ-026 resetn=0 SHALL immediately, without clock, force IDLE, hi=0, lo=0, done=0, div_zero=0, clear internal iteration state; op_ready=1 during reset.
REQ-027 Reset mid-operation SHALL abort it with no done pulse; first accept after release SHALL behave normally.
REQ-028 Accept SHALL not occur while resetn=0.

Verification (DATA_WIDTH=32)
REQ-029 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> at E33 hi=0xFFFFFFFE lo=0x00000001, done 1 cycle, op_ready low E1..E32.
REQ-030 MULT A=-3 B=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; MULT A=-3 B=-5 -> hi=0 lo=0x0000000F.
REQ-031 DIV A=-7 B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU A=7 B=2 -> lo=3 hi=1; DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-032 MTHI 0x1234, MTLO 0x5678, then DIVU B=0 -> at E1 done=1 div_zero=1, hi=0x1234 lo=0x5678 retained.
REQ-033 MULTU started, resetn pulsed low mid-RUN (iteration 10) -> hi=lo=0 instantly, op_ready=1, no done; following MULTU 6*7 -> lo=42 hi=0.
REQ-034 op_valid held high with changing A/B during RUN -> ignored; result uses captured operands; second op accepted at E34 only.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, with sign fix-up in a final FIX cycle.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  done,
    output logic                  div_zero
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_prod;     // mult: {acc, multiplier}; div: {remainder, quotient}
    logic [N-1:0]    r_a, r_b;
    logic            r_is_div, r_neg, r_rneg, r_dz;
    logic [N-1:0]    r_hi, r_lo;
    logic            r_done, r_dz_out;

    logic            w_is_md, w_op_signed, w_a_neg, w_b_neg, w_bzero, w_last;
    logic [N-1:0]    w_a_mag, w_b_mag;
    logic [N:0]      w_sum, w_shl, w_sub;
    logic            w_ge;
    logic [2*N-1:0]  w_pneg;
    logic [N-1:0]    w_qneg, w_rneg;

    assign w_is_md     = ~op[2];
    assign w_op_signed = ~op[0];
    assign w_a_neg     = w_op_signed & A[N-1];
    assign w_b_neg     = w_op_signed & B[N-1];
    assign w_a_mag     = w_a_neg ? -A : A;
    assign w_b_mag     = w_b_neg ? -B : B;
    assign w_bzero     = (B == '0);
    assign w_last      = (r_cnt == CW'(N-1));

    always_comb begin
        w_sum  = {1'b0, r_prod[2*N-1:N]} + {1'b0, (r_prod[0] ? r_a : {N{1'b0}})};
        w_shl  = {r_prod[2*N-1:N], r_prod[N-1]};
        w_ge   = (w_shl >= {1'b0, r_b});
        w_sub  = w_shl - {1'b0, r_b};
        w_pneg = -r_prod;
        w_qneg = -r_prod[N-1:0];
        w_rneg = -r_prod[2*N-1:N];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (op_valid && w_is_md) w_next = (op[1] && w_bzero) ? S_FIX : S_RUN;
            S_RUN:  if (w_last) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            case (r_state)
                S_IDLE: if (op_valid) begin
                    if (op == OP_MTHI) r_hi <= A;
                    if (op == OP_MTLO) r_lo <= A;
                    if (w_is_md) begin
                        r_is_div <= op[1];
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_rneg   <= w_a_neg;
                        r_dz     <= op[1] & w_bzero;
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_prod   <= op[1] ? {{N{1'b0}}, w_a_mag} : {{N{1'b0}}, w_b_mag};
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div)
                        r_prod <= {(w_ge ? w_sub[N-1:0] : w_shl[N-1:0]), r_prod[N-2:0], w_ge};
                    else
                        r_prod <= {w_sum, r_prod[N-1:1]};
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_dz_out <= 1'b1;
                    end else if (r_is_div) begin
                        // quotient takes the sign of A^B, remainder the sign of the dividend
                        r_lo <= r_neg  ? w_qneg : r_prod[N-1:0];
                        r_hi <= r_rneg ? w_rneg : r_prod[2*N-1:N];
                    end else begin
                        {r_hi, r_lo} <= r_neg ? w_pneg : r_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_ready = (r_state == S_IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign done     = r_done;
    assign div_zero = r_dz_out;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand-written corner sequences
// and random operations compared against an arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] hi, lo;
    logic        done, div_zero;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .A(A), .B(B), .hi(hi), .lo(lo), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
        bit          edz;
        int          elat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO state.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int elat, output bit edz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        edz = 0;
        elat = 33;
        case (o)
            3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    edz = 1; elat = 1;
                end else if (o == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: begin m_hi = a; elat = 0; end
            3'd5: begin m_lo = a; elat = 0; end
            default: elat = 0;
        endcase
    endtask

    // Issues one request and watches the handshake until done (or a short window).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit dz, output bit bad);
        bit busy;
        int lim;
        busy = (o < 3'd4);
        lim = busy ? 40 : 3;
        lat = 0; dz = 0; bad = 0;
        @(negedge clk);
        op_valid = 1; op = o; A = a; B = b;
        @(negedge clk);
        op_valid = 0; A = $urandom; B = $urandom;
        if (op_ready == busy) bad = 1;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (done) begin lat = k; dz = div_zero; break; end
            if (div_zero) bad = 1;
            if (op_ready == busy) bad = 1;
        end
        if (lat > 0) begin
            @(negedge clk);
            if (done || div_zero || !op_ready) bad = 1;
        end
    endtask

    task automatic run_checked(input string nm, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
        int lat, elat;
        bit dz, bad, edz;
        model(o, a, b, elat, edz);
        run_op(o, a, b, lat, dz, bad);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_hi"}, hi, m_hi);
        chk({nm, "_lo"}, lo, m_lo);
        chk({nm, "_dz"}, dz, edz);
        chk({nm, "_hs"}, bad, 0);
    endtask

    initial begin
        int lat, elat;
        bit dz, bad, edz;
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        logic [31:0] pool[6];

        tbl[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33};
        tbl[1]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33};
        tbl[2]  = '{3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 0, 33};
        tbl[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33};
        tbl[4]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 0, 33};
        tbl[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33};
        tbl[6]  = '{3'd4, 32'h00001234, 32'hDEAD,     32'h00001234, 32'h80000000, 0, 0};
        tbl[7]  = '{3'd5, 32'h00005678, 32'hBEEF,     32'h00001234, 32'h00005678, 0, 0};
        tbl[8]  = '{3'd3, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 1, 1};
        tbl[9]  = '{3'd2, 32'hFFFFFFF0, 32'd0,        32'h00001234, 32'h00005678, 1, 1};
        tbl[10] = '{3'd6, 32'hFFFF0000, 32'd9,        32'h00001234, 32'h00005678, 0, 0};

        // Reset state, and no accept while held in reset
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", {done, div_zero}, 0);
        chk("rst_ready", op_ready, 1);
        op_valid = 1; op = 3'd4; A = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_noacc_hi", hi, 0);
        op_valid = 0;
        resetn = 1;

        for (int i = 0; i < 11; i++) begin
            model(tbl[i].op, tbl[i].a, tbl[i].b, elat, edz);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, dz, bad);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].elat);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].ehi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].elo);
            chk($sformatf("tbl%0d_dz", i), dz, tbl[i].edz);
            chk($sformatf("tbl%0d_hs", i), bad, 0);
        end

        // Reset pulse in the middle of a multiply
        @(negedge clk);
        op_valid = 1; op = 3'd1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge clk);
        op_valid = 0;
        repeat (10) @(negedge clk);
        resetn = 0;
        #1;
        chk("midrst_hilo", {hi, lo}, 0);
        chk("midrst_ready", op_ready, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        resetn = 1;
        m_hi = 0; m_lo = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
        chk("midrst_nodone", lat, 0);
        run_checked("post_rst", 3'd1, 32'd6, 32'd7);
        chk("post_rst_lo42", lo, 42);

        // op_valid held high with wandering operands during RUN
        @(negedge clk);
        op_valid = 1; op = 3'd1; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        lat = 0; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            A = $urandom; B = $urandom;
            @(negedge clk);
            if (done) begin lat = k; break; end
            if (op_ready) bad = 1;
        end
        chk("hold_lat", lat, 33);
        chk("hold_busy", bad, 0);
        chk("hold_res", {hi, lo}, 64'd3000);
        A = 32'd11; B = 32'd13;
        @(negedge clk);
        op_valid = 0;
        chk("hold_acc_e34", {op_ready, done}, 2'b00);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        chk("hold2_lat", lat, 33);
        chk("hold2_res", {hi, lo}, 64'd143);
        m_hi = 0; m_lo = 143;

        // Random operations against the model
        pool[0] = 32'h80000000; pool[1] = 32'hFFFFFFFF; pool[2] = 32'h7FFFFFFF;
        pool[3] = 32'd1;        pool[4] = 32'd0;        pool[5] = 32'hFFFFFFFE;
        for (int i = 0; i < 40; i++) begin
            ro = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            run_checked($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
